// File: rtl/mod_chk_pkg.sv
// rtl/mod_chk_pkg.sv - shared types and step rule for the mod-N counter checker
package mod_chk_pkg;

    typedef enum logic [1:0] {ALIGN, TRACK, HALT} chk_state_t;

    typedef enum logic [1:0] {E_NONE, E_RANGE, E_STEP, E_RSTVAL} err_code_t;

    // Next counter value, kept in qw bits so an out-of-range cur still yields a defined answer.
    function automatic int unsigned step_val(input int unsigned cur, input logic up,
                                             input int unsigned modulus, input int unsigned qw);
        int unsigned mask;
        mask = (32'd1 << qw) - 32'd1;
        if (up)
            return (cur == modulus - 32'd1) ? 32'd0 : ((cur + 32'd1) & mask);
        return (cur == 32'd0) ? modulus - 32'd1 : ((cur - 32'd1) & mask);
    endfunction

endpackage

// File: rtl/mod_count_checker_if.sv
// rtl/mod_count_checker_if.sv - observed counter signals and checker results
interface mod_count_checker_if #(
    parameter int unsigned QW = 3,
    parameter int unsigned CW = 8
);
    logic          dir;
    logic [QW-1:0] q;
    logic          clear_stats;
    logic          err;
    logic [1:0]    err_code;
    logic          err_sticky;
    logic [QW-1:0] expected_q;
    logic          tracking;
    logic [CW-1:0] wrap_up_cnt;
    logic [CW-1:0] wrap_dn_cnt;
    logic [CW-1:0] rev_cnt;
    logic [CW-1:0] err_cnt;

    modport master (
        output dir, q, clear_stats,
        input  err, err_code, err_sticky, expected_q, tracking,
        input  wrap_up_cnt, wrap_dn_cnt, rev_cnt, err_cnt
    );

    modport slave (
        input  dir, q, clear_stats,
        output err, err_code, err_sticky, expected_q, tracking,
        output wrap_up_cnt, wrap_dn_cnt, rev_cnt, err_cnt
    );
endinterface

// File: rtl/mod_step_predict.sv
// rtl/mod_step_predict.sv - combinational next-value predictor for a mod-N up/down counter
module mod_step_predict
    import mod_chk_pkg::*;
#(
    parameter int unsigned MODULUS = 6,
    parameter int unsigned QW      = 3
) (
    input  logic [QW-1:0] q,
    input  logic          dir,
    output logic [QW-1:0] q_next
);

    assign q_next = QW'(step_val(32'(q), dir, MODULUS, QW));

endmodule

// File: rtl/mod_count_checker.sv
// rtl/mod_count_checker.sv - predicts each counter step, flags mismatches, keeps saturating stats
module mod_count_checker
    import mod_chk_pkg::*;
#(
    parameter int unsigned MODULUS     = 6,
    parameter int unsigned QW          = 3,
    parameter int unsigned CW          = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input logic               clk,
    input logic               reset,
    mod_count_checker_if.slave bus
);

    localparam logic [QW-1:0] QMAX = QW'(MODULUS - 1);

    chk_state_t    state;
    logic [QW-1:0] prev_q;
    logic          prev_dir;
    logic [QW-1:0] pred_q;
    logic          err_now;
    err_code_t     code_now;
    logic          wrap_up_now;
    logic          wrap_dn_now;
    logic          rev_now;

    mod_step_predict #(.MODULUS(MODULUS), .QW(QW)) u_predict (
        .q      (prev_q),
        .dir    (prev_dir),
        .q_next (pred_q)
    );

    // Clear is applied before the increment so an event in the clearing cycle still counts once.
    function automatic logic [CW-1:0] bump(input logic [CW-1:0] cur, input logic clr, input logic inc);
        logic [CW-1:0] base;
        base = clr ? '0 : cur;
        return (inc && base != '1) ? base + CW'(1) : base;
    endfunction

    always_comb begin
        code_now = E_NONE;
        case (state)
            ALIGN: if (bus.q != '0) code_now = E_RSTVAL;
            TRACK: begin
                if (32'(bus.q) >= MODULUS)  code_now = E_RANGE;
                else if (bus.q != pred_q)   code_now = E_STEP;
            end
            default: code_now = E_NONE;
        endcase
        err_now     = (code_now != E_NONE);
        wrap_up_now = (state == TRACK) && !err_now && prev_dir  && prev_q == QMAX && bus.q == '0;
        wrap_dn_now = (state == TRACK) && !err_now && !prev_dir && prev_q == '0  && bus.q == QMAX;
        rev_now     = (state == TRACK) && (bus.dir != prev_dir);
    end

    assign bus.tracking = (state == TRACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ALIGN;
            prev_q          <= '0;
            prev_dir        <= 1'b0;
            bus.err         <= 1'b0;
            bus.err_code    <= 2'd0;
            bus.err_sticky  <= 1'b0;
            bus.expected_q  <= '0;
            bus.wrap_up_cnt <= '0;
            bus.wrap_dn_cnt <= '0;
            bus.rev_cnt     <= '0;
            bus.err_cnt     <= '0;
        end else begin
            bus.err         <= err_now;
            bus.err_sticky  <= err_now | (bus.err_sticky & ~bus.clear_stats);
            bus.wrap_up_cnt <= bump(bus.wrap_up_cnt, bus.clear_stats, wrap_up_now);
            bus.wrap_dn_cnt <= bump(bus.wrap_dn_cnt, bus.clear_stats, wrap_dn_now);
            bus.rev_cnt     <= bump(bus.rev_cnt,     bus.clear_stats, rev_now);
            bus.err_cnt     <= bump(bus.err_cnt,     bus.clear_stats, err_now);
            if (err_now)
                bus.err_code <= code_now;
            if (state != HALT) begin
                // Capture unconditionally so tracking resynchronises after a bad sample.
                prev_q         <= bus.q;
                prev_dir       <= bus.dir;
                bus.expected_q <= (state == TRACK) ? pred_q : '0;
                state          <= (err_now && STOP_ON_ERR) ? HALT : TRACK;
            end
        end
    end

endmodule

// File: tb/tb_mod_count_checker.sv
// tb/tb_mod_count_checker.sv - directed and random stimulus against a behavioural checker model
module tb_mod_count_checker;

    localparam int MOD  = 6;
    localparam int QW   = 3;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dir = 1'b0;
    logic          clear_stats = 1'b0;
    logic [QW-1:0] q_drv = '0;

    always #5 clk = ~clk;

    mod_count_checker_if #(.QW(QW), .CW(CW)) if0 ();
    mod_count_checker_if #(.QW(QW), .CW(CW)) if1 ();

    assign if0.dir = dir;
    assign if0.q = q_drv;
    assign if0.clear_stats = clear_stats;
    assign if1.dir = dir;
    assign if1.q = q_drv;
    assign if1.clear_stats = clear_stats;

    mod_count_checker #(.MODULUS(MOD), .QW(QW), .CW(CW), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    mod_count_checker #(.MODULUS(MOD), .QW(QW), .CW(CW), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    int cnt = 0;
    int n_vec = 0;
    int n_fail = 0;

    // Reference model state; index 0 continues after errors, index 1 stops on the first one.
    int m_phase[2], m_prev[2], m_pdir[2], m_err[2], m_code[2], m_sticky[2];
    int m_exp[2], m_wu[2], m_wd[2], m_rev[2], m_ec[2];

    function automatic int nxt(input int v, input int up);
        if (up != 0) return (v == MOD - 1) ? 0 : (v + 1) % (1 << QW);
        return (v == 0) ? MOD - 1 : v - 1;
    endfunction

    function automatic int sat(input int c, input int clr, input int inc);
        int b;
        b = (clr != 0) ? 0 : c;
        return (inc != 0 && b < CMAX) ? b + 1 : b;
    endfunction

    task automatic model(input int k, input int r, input int d, input int clr, input int qv);
        int e, wu, wd, rv;
        e = 0; wu = 0; wd = 0; rv = 0;
        if (r != 0) begin
            m_phase[k] = 0; m_prev[k] = 0; m_pdir[k] = 0; m_err[k] = 0; m_code[k] = 0;
            m_sticky[k] = 0; m_exp[k] = 0; m_wu[k] = 0; m_wd[k] = 0; m_rev[k] = 0; m_ec[k] = 0;
        end else begin
            if (m_phase[k] == 0) begin
                m_exp[k] = 0;
                if (qv != 0) e = 3;
            end else if (m_phase[k] == 1) begin
                m_exp[k] = nxt(m_prev[k], m_pdir[k]);
                if (qv >= MOD) e = 1;
                else if (qv != m_exp[k]) e = 2;
                wu = (e == 0 && m_pdir[k] == 1 && m_prev[k] == MOD - 1 && qv == 0) ? 1 : 0;
                wd = (e == 0 && m_pdir[k] == 0 && m_prev[k] == 0 && qv == MOD - 1) ? 1 : 0;
                rv = (d != m_pdir[k]) ? 1 : 0;
            end
            m_err[k] = (e != 0) ? 1 : 0;
            if (e != 0) m_code[k] = e;
            m_sticky[k] = (e != 0 || (m_sticky[k] != 0 && clr == 0)) ? 1 : 0;
            m_wu[k]  = sat(m_wu[k], clr, wu);
            m_wd[k]  = sat(m_wd[k], clr, wd);
            m_rev[k] = sat(m_rev[k], clr, rv);
            m_ec[k]  = sat(m_ec[k], clr, m_err[k]);
            if (m_phase[k] != 2) begin
                m_prev[k] = qv;
                m_pdir[k] = d;
                m_phase[k] = (e != 0 && k == 1) ? 2 : 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "stop0" : "stop1";
            chk({p, ".err"},        (k != 0) ? 32'(if1.err)         : 32'(if0.err),         m_err[k]);
            chk({p, ".err_code"},   (k != 0) ? 32'(if1.err_code)    : 32'(if0.err_code),    m_code[k]);
            chk({p, ".err_sticky"}, (k != 0) ? 32'(if1.err_sticky)  : 32'(if0.err_sticky),  m_sticky[k]);
            chk({p, ".expected_q"}, (k != 0) ? 32'(if1.expected_q)  : 32'(if0.expected_q),  m_exp[k]);
            chk({p, ".tracking"},   (k != 0) ? 32'(if1.tracking)    : 32'(if0.tracking),    (m_phase[k] == 1) ? 1 : 0);
            chk({p, ".wrap_up"},    (k != 0) ? 32'(if1.wrap_up_cnt) : 32'(if0.wrap_up_cnt), m_wu[k]);
            chk({p, ".wrap_dn"},    (k != 0) ? 32'(if1.wrap_dn_cnt) : 32'(if0.wrap_dn_cnt), m_wd[k]);
            chk({p, ".rev"},        (k != 0) ? 32'(if1.rev_cnt)     : 32'(if0.rev_cnt),     m_rev[k]);
            chk({p, ".err_cnt"},    (k != 0) ? 32'(if1.err_cnt)     : 32'(if0.err_cnt),     m_ec[k]);
        end
    endtask

    // One clock: drive inputs, advance model and the ideal counter at the edge, check #1 later.
    task automatic step(input int r, input int d, input int clr = 0, input int ovr = 0, input int ov = 0);
        int qv;
        qv = (ovr != 0) ? ov : cnt;
        reset = r[0];
        dir = d[0];
        clear_stats = clr[0];
        q_drv = qv[QW-1:0];
        @(posedge clk);
        model(0, r, d, clr, qv);
        model(1, r, d, clr, qv);
        cnt = (r != 0) ? 0 : ((d != 0) ? (cnt + 1) % MOD : (cnt + MOD - 1) % MOD);
        #1;
        check_all();
    endtask

    initial begin
        // Count up through two wraps.
        step(1, 1); step(1, 1);
        for (int i = 0; i < 14; i++) step(0, 1);
        chk("plan.wrap_up", 32'(if0.wrap_up_cnt), 2);

        // Count down through two wraps.
        step(1, 0);
        for (int i = 0; i < 8; i++) step(0, 0);
        chk("plan.wrap_dn", 32'(if0.wrap_dn_cnt), 2);

        // Out-of-range sample, then continue with the real counter.
        step(1, 1);
        for (int i = 0; i < 3; i++) step(0, 1);
        step(0, 1, 0, 1, 7);
        chk("plan.range_code", 32'(if0.err_code), 1);
        for (int i = 0; i < 4; i++) step(0, 1);

        // Step mismatch: 2 where 4 is expected.
        step(1, 1);
        for (int i = 0; i < 4; i++) step(0, 1);
        step(0, 1, 0, 1, 2);
        chk("plan.step_exp", 32'(if0.expected_q), 4);
        for (int i = 0; i < 3; i++) step(0, 1);
        chk("plan.halt_track", 32'(if1.tracking), 0);
        chk("plan.halt_errcnt", 32'(if1.err_cnt), 1);

        // Direction reversals, clear, and clear colliding with an error.
        step(1, 1);
        for (int i = 0; i < 12; i++) step(0, ((i / 3) % 2 == 0) ? 1 : 0);
        chk("plan.rev", 32'(if0.rev_cnt), 3);
        step(0, 1, 1);
        step(0, 1);
        step(0, 1, 1, 1, 7);
        step(0, 1);

        // Reset mid-count, clean realign, then a bad post-reset value.
        step(1, 1);
        for (int i = 0; i < 5; i++) step(0, 1);
        step(1, 1);
        step(0, 1); step(0, 1);
        step(1, 1);
        step(0, 1, 0, 1, 2);
        chk("plan.rstval", 32'(if0.err_code), 3);
        step(0, 1);

        // Randomised traffic including resets, clears and corrupted samples.
        for (int i = 0; i < 600; i++)
            step(($urandom % 40 == 0) ? 1 : 0, int'($urandom % 2), ($urandom % 16 == 0) ? 1 : 0,
                 ($urandom % 8 == 0) ? 1 : 0, int'($urandom % 8));

        // Saturation of every statistic.
        step(1, 1);
        for (int i = 0; i < 1600; i++) step(0, 1);
        chk("sat.wrap_up", 32'(if0.wrap_up_cnt), CMAX);
        for (int i = 0; i < 300; i++) step(0, i % 2);
        chk("sat.rev", 32'(if0.rev_cnt), CMAX);
        for (int i = 0; i < 300; i++) step(0, 1, 0, 1, 7);
        chk("sat.err_cnt", 32'(if0.err_cnt), CMAX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_count_checker.md
Name: mod_count_checker

Overview:
- Downstream monitor for the mod-N up/down counter; sits beside the DUT in the counter testbench/top and consumes the counter's q and dir.
- Each cycle it predicts the counter's next value from the previous q and dir, compares the prediction with the observed q, and flags mismatches.
- Keeps saturating statistics: up-wraps, down-wraps, direction reversals and errors.
- Synthesizable, so the same block can be used as an on-chip sanity checker.

Parameters:
- MODULUS, 6, count modulus; legal q range is 0..MODULUS-1.
- QW, 3, width of q; must satisfy 2**QW >= MODULUS.
- CW, 8, width of each statistics counter.
- STOP_ON_ERR, 0, when 1 the checker enters HALT on the first error.

Ports:
- clk  input  1  clock, shared with the counter.
- reset  input  1  synchronous, active-high; the same signal that drives the counter's reset.
- dir  input  1  counter direction (1 = up, 0 = down), as driven to the counter.
- q  input  QW  counter output.
- clear_stats  input  1  synchronous clear of statistics and err_sticky; does not change FSM state.
- err  output  1  one-cycle error pulse.
- err_code  output  2  0 = none, 1 = out of range, 2 = step mismatch, 3 = bad post-reset value; holds the code of the last error.
- err_sticky  output  1  set on any error; cleared by reset or clear_stats.
- expected_q  output  QW  prediction that the current q is checked against (registered).
- tracking  output  1  high while the FSM is in TRACK.
- wrap_up_cnt  output  CW  count of MODULUS-1 -> 0 transitions taken while counting up.
- wrap_dn_cnt  output  CW  count of 0 -> MODULUS-1 transitions taken while counting down.
- rev_cnt  output  CW  count of dir reversals while tracking.
- err_cnt  output  CW  count of error events.

Behaviour:
- Reset is synchronous, active-high, on clk. While reset is high:
  - FSM goes to ALIGN; prev_q = 0; prev_dir = 0.
  - All outputs are 0: err, err_code, err_sticky, expected_q, tracking, all counters.
- Step function:
  - up: q == MODULUS-1 -> 0, otherwise q+1.
  - down: q == 0 -> MODULUS-1, otherwise q-1.
  - Arithmetic is done in QW bits; no intermediate overflow is allowed.
- ALIGN (first edge with reset low):
  - Check q == 0; otherwise err_code = 3.
  - Capture prev_q = q and prev_dir = dir.
  - Go to TRACK, or to HALT if an error occurred and STOP_ON_ERR = 1.
- TRACK (each edge):
  - expected = step(prev_q, prev_dir).
  - Error priority: q >= MODULUS -> code 1; else q != expected -> code 2.
  - Capture prev_q = q and prev_dir = dir unconditionally, so the checker resynchronises after an error.
  - wrap_up_cnt increments if prev_dir = 1, prev_q = MODULUS-1 and q = 0.
  - wrap_dn_cnt increments if prev_dir = 0, prev_q = 0 and q = MODULUS-1.
  - rev_cnt increments if dir != prev_dir.
  - A wrap is counted only if that cycle has no error.
- HALT:
  - Entered only when STOP_ON_ERR = 1.
  - No further checks or counting; err stays low; err_sticky and err_code hold.
  - Exited only by reset.
- Latency: err, err_code, counters and expected_q update at the edge that samples q; they are visible one cycle after the sampled q.
- Counters saturate at 2**CW-1 and never wrap.
- clear_stats:
  - Zeroes all four counters and err_sticky.
  - If an error occurs in the same cycle, the error wins: err_sticky = 1 and err_cnt = 1.
- Reset mid-operation: reset has priority over everything, and the checker re-enters ALIGN.
- A counter reset that is not shared with the checker is out of scope; it will show up as code 2.

Decomposition:
- Package mod_chk_pkg holds:
  - enum chk_state_t {ALIGN, TRACK, HALT};
  - enum err_code_t {E_NONE, E_RANGE, E_STEP, E_RSTVAL};
  - a parameterised step function.
- Sub-module mod_step_predict: combinational; inputs q, dir; output next value; parameters MODULUS and QW. It is shared with future counter models.

Test Plan:
- Reset held 2 cycles, then dir = 1 for 14 cycles with the correct counter -> q sequence 0,1,2,3,4,5,0,1,...; err never set; wrap_up_cnt = 2; tracking high from cycle 2.
- dir = 0 from reset for 8 cycles -> q sequence 0,5,4,3,2,1,0,5; wrap_dn_cnt = 2; err = 0.
- Force q = 3'd7 for one cycle in TRACK -> err pulse with err_code = 1; err_cnt = 1; err_sticky = 1; the next correct step from 7 is flagged only if it is inconsistent.
- Force q = 2 when 4 is expected -> err_code = 2 and expected_q = 4; with STOP_ON_ERR = 1, tracking drops and err_cnt stays 1.
- Alternate dir every 3 cycles for 12 cycles -> rev_cnt = 3; then pulse clear_stats -> all counters 0 and err_sticky 0.
- Assert reset mid-count at q = 4 -> outputs 0 next cycle; after release ALIGN sees 0 with no error; a non-zero post-reset q gives err_code = 3.
